// File: rtl/fetch_engine_mo.sv
// Streams a W block then an X block from byte memory to the compute core, keeping up to
// MaxOutstanding reads in flight behind a credit-guarded response FIFO.
module fetch_engine_mo #(
  parameter int unsigned AddrWidth      = 8,
  parameter int unsigned DataWidth      = 8,
  parameter int unsigned WDepth         = 16,
  parameter int unsigned XDepth         = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [1:0]           op_code_i,
  input  logic [AddrWidth-1:0] cfg_data_i,
  output logic                 m_req_vld_o,
  input  logic                 m_req_rdy_i,
  output logic [AddrWidth-1:0] m_req_addr_o,
  input  logic                 m_rsp_vld_i,
  input  logic [DataWidth-1:0] m_rsp_data_i,
  output logic                 src_vld_o,
  input  logic                 src_rdy_i,
  output logic [DataWidth-1:0] src_data_o,
  output logic                 src_seg_o,
  output logic                 src_last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned Total = WDepth + XDepth;
  localparam int unsigned IdxW  = $clog2(Total + 1);
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StAbort} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] w_base_q, w_base_d, x_base_q, x_base_d;
  logic [AddrWidth-1:0] stride_q, stride_d, addr_q, addr_d;
  logic [IdxW-1:0]      idx_q, idx_d, push_idx_q, push_idx_d;
  logic [CntW-1:0]      inflight_q, inflight_d, count_q, count_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 done_q, done_d;

  // Entry layout: {last, seg, data}
  logic [DataWidth+1:0] fifo_mem [MaxOutstanding];
  logic [DataWidth+1:0] head;

  logic            active, abort_now, req_vld, req_fire, rsp_ret, push, pop;
  logic            push_seg, push_last, head_last;
  logic [CntW:0]   occupancy;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign head = fifo_mem[rd_ptr_q];

  always_comb begin
    active    = (state_q == StRun) || (state_q == StDrain);
    abort_now = active && start_i && (op_code_i == 2'b11);
    // Credits cover both in-flight reads and buffered beats, so a push never overflows.
    occupancy = {1'b0, inflight_q} + {1'b0, count_q};
    req_vld   = (state_q == StRun) && (idx_q < IdxW'(Total)) &&
                (occupancy < (CntW + 1)'(MaxOutstanding));
    req_fire  = req_vld && m_req_rdy_i;
    rsp_ret   = m_rsp_vld_i && (inflight_q != '0);
    push      = rsp_ret && active && !abort_now;
    pop       = (count_q != '0) && src_rdy_i;
    push_seg  = push_idx_q >= IdxW'(WDepth);
    push_last = push_idx_q == IdxW'(Total - 1);
    head_last = head[DataWidth+1];
  end

  always_comb begin
    state_d    = state_q;
    w_base_d   = w_base_q;
    x_base_d   = x_base_q;
    stride_d   = stride_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    push_idx_d = push_idx_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    done_d     = 1'b0;

    if (req_fire && !rsp_ret) begin
      inflight_d = inflight_q + CntW'(1);
    end else if (!req_fire && rsp_ret) begin
      inflight_d = inflight_q - CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          unique case (op_code_i)
            2'b00: w_base_d = cfg_data_i;
            2'b01: x_base_d = cfg_data_i;
            2'b10: begin
              stride_d   = (cfg_data_i == '0) ? AddrWidth'(1) : cfg_data_i;
              addr_d     = w_base_q;
              idx_d      = '0;
              push_idx_d = '0;
              state_d    = StRun;
            end
            default: ;
          endcase
        end
      end
      StRun, StDrain: begin
        if (abort_now) begin
          state_d  = StAbort;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else begin
          if (req_fire) begin
            idx_d  = idx_q + IdxW'(1);
            addr_d = (idx_q == IdxW'(WDepth - 1)) ? x_base_q : addr_q + stride_q;
            if (idx_q == IdxW'(Total - 1)) state_d = StDrain;
          end
          if (push) begin
            wr_ptr_d   = ptr_inc(wr_ptr_q);
            push_idx_d = push_idx_q + IdxW'(1);
          end
          if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            if (head_last) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
          if (push && !pop) begin
            count_d = count_q + CntW'(1);
          end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
          end
        end
      end
      StAbort: begin
        if (inflight_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      w_base_q   <= '0;
      x_base_q   <= '0;
      stride_q   <= AddrWidth'(1);
      addr_q     <= '0;
      idx_q      <= '0;
      push_idx_q <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_base_q   <= w_base_d;
      x_base_q   <= x_base_d;
      stride_q   <= stride_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      push_idx_q <= push_idx_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= {push_last, push_seg, m_rsp_data_i};
  end

  // Payload outputs are gated so every output reads 0 whenever nothing is offered.
  assign m_req_vld_o  = req_vld;
  assign m_req_addr_o = req_vld ? addr_q : '0;
  assign src_vld_o    = count_q != '0;
  assign src_data_o   = src_vld_o ? head[DataWidth-1:0] : '0;
  assign src_seg_o    = src_vld_o && head[DataWidth];
  assign src_last_o   = src_vld_o && head_last;
  assign busy_o       = state_q != StIdle;
  assign done_o       = done_q;

endmodule
